// File: rtl/conv_window_engine.sv
// Valid-mode 5x5 convolution over a square Q8.8 block, one multiply-accumulate per cycle.
// Each finished pixel is streamed out with its linear output index on a one-cycle valid strobe.
module conv_window_engine #(
  parameter int DATA_W  = 16,
  parameter int K       = 5,
  parameter int MAP_MAX = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       size,
  input  logic [DATA_W-1:0] map    [0:MAP_MAX*MAP_MAX-1],
  input  logic [DATA_W-1:0] kernel [0:K*K-1],
  output logic [DATA_W-1:0] outData,
  output logic [15:0]       outAddr,
  output logic              outValid,
  output logic              done,
  output logic              error
);

  localparam int AW    = $clog2(MAP_MAX*MAP_MAX);
  localparam int EW    = $clog2(MAP_MAX+1);
  localparam int KW    = $clog2(K*K);
  localparam int IW    = $clog2(K);
  localparam int FRAC  = 8;
  localparam int PW    = 2*DATA_W;
  localparam int ACC_W = PW + 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state;
  logic [EW-1:0]           n_r, o_r, r, c;
  logic [IW-1:0]           i, j;
  logic [KW-1:0]           k_idx;
  logic [AW-1:0]           row_start, pix_base, row_addr;
  logic [15:0]             out_idx;
  logic signed [ACC_W-1:0] acc;

  logic [AW-1:0]           map_addr, next_row;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] shifted;
  logic [DATA_W-1:0]       sat;

  // row_addr tracks (r+i)*N + c; the tap address only adds j, so no multiplier on the address path.
  always_comb begin
    map_addr = row_addr + AW'(j);
    next_row = row_start + AW'(n_r);
    prod     = $signed(map[map_addr]) * $signed(kernel[k_idx]);
    shifted  = acc >>> FRAC;
    if (&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1])
      sat = shifted[DATA_W-1:0];
    else if (shifted[ACC_W-1])
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n_r       <= '0;
      o_r       <= '0;
      r         <= '0;
      c         <= '0;
      i         <= '0;
      j         <= '0;
      k_idx     <= '0;
      row_start <= '0;
      pix_base  <= '0;
      row_addr  <= '0;
      out_idx   <= '0;
      acc       <= '0;
      outData   <= '0;
      outAddr   <= '0;
      outValid  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            r         <= '0;
            c         <= '0;
            i         <= '0;
            j         <= '0;
            k_idx     <= '0;
            row_start <= '0;
            pix_base  <= '0;
            row_addr  <= '0;
            out_idx   <= '0;
            acc       <= '0;
            n_r       <= size[EW-1:0];
            o_r       <= size[EW-1:0] - EW'(K-1);
            if (size < 16'(K) || size > 16'(MAP_MAX)) begin
              error <= 1'b1;
              state <= DONE;
            end else begin
              error <= 1'b0;
              state <= MAC;
            end
          end
        end
        MAC: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            acc   <= acc + ACC_W'(prod);
            k_idx <= (k_idx == KW'(K*K-1)) ? '0 : k_idx + 1'b1;
            if (j == IW'(K-1)) begin
              j <= '0;
              if (i == IW'(K-1)) begin
                i     <= '0;
                state <= WRITE;
              end else begin
                i        <= i + 1'b1;
                row_addr <= row_addr + AW'(n_r);
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        WRITE: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            outValid <= 1'b1;
            outAddr  <= out_idx;
            outData  <= sat;
            acc      <= '0;
            out_idx  <= out_idx + 1'b1;
            if (c == o_r - 1'b1) begin
              c         <= '0;
              r         <= r + 1'b1;
              row_start <= next_row;
              pix_base  <= next_row;
              row_addr  <= next_row;
              state     <= (r == o_r - 1'b1) ? DONE : MAC;
            end else begin
              c        <= c + 1'b1;
              pix_base <= pix_base + 1'b1;
              row_addr <= pix_base + 1'b1;
              state    <= MAC;
            end
          end
        end
        default: begin
          if (enable) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            error <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Directed bench for conv_window_engine: hand-computed pixel values, strobe timing,
// size rejection, abort, hold-after-done and asynchronous reset mid-run.
module tb_conv_window_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] size;
  logic [15:0] map_t    [0:1023];
  logic [15:0] kernel_t [0:24];
  logic [15:0] outData;
  logic [15:0] outAddr;
  logic        outValid;
  logic        done;
  logic        error;

  conv_window_engine #(.DATA_W(16), .K(5), .MAP_MAX(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .size(size),
    .map(map_t), .kernel(kernel_t),
    .outData(outData), .outAddr(outAddr), .outValid(outValid),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int e0 = 0;
  int overlap = 0;
  logic [15:0] q_data[$];
  logic [15:0] q_addr[$];
  int          q_time[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (outValid) begin
      q_data.push_back(outData);
      q_addr.push_back(outAddr);
      q_time.push_back(cyc - e0);
    end
    if (outValid && done) overlap++;
  end

  task automatic fill(input logic [15:0] mv, input logic [15:0] kv);
    for (int k = 0; k < 1024; k++) map_t[k] = mv;
    for (int k = 0; k < 25; k++) kernel_t[k] = kv;
  endtask

  // Leaves the bench just after edge E0 with e0 marking it.
  task automatic start_run(input logic [15:0] n);
    @(negedge clk);
    q_data.delete(); q_addr.delete(); q_time.delete();
    size = n;
    enable = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic stop_run;
    @(negedge clk) enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; size = 16'd6;
    fill(16'h0000, 16'h0000);
    #3;
    vectors++;
    if ({outData, outAddr, outValid, done, error} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h/%h/%b%b%b exp 0/0/000", outData, outAddr, outValid, done, error);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (done !== 1'b0 || outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start got done=%b valid=%b exp 0 0", done, outValid);
    end
  endtask

  task automatic test_unit_conv;
    int lat;
    fill(16'h0100, 16'h0100);
    start_run(16'd6);
    wait_done(400, lat);
    vectors++;
    if (lat !== 105) begin
      miscompares++;
      $display("FAIL unit_done_latency got %0d exp 105", lat);
    end
    vectors++;
    if (q_data.size() !== 4) begin
      miscompares++;
      $display("FAIL unit_strobes got %0d exp 4", q_data.size());
    end
    for (int n = 0; n < 4 && n < q_data.size(); n++) begin
      vectors++;
      if (q_data[n] !== 16'h1900 || q_addr[n] !== 16'(n) || q_time[n] !== 26*(n+1)) begin
        miscompares++;
        $display("FAIL unit_pixel%0d got %h@%0d t%0d exp 1900@%0d t%0d",
                 n, q_data[n], q_addr[n], q_time[n], n, 26*(n+1));
      end
    end
    vectors++;
    if (error !== 1'b0 || overlap !== 0) begin
      miscompares++;
      $display("FAIL unit_flags got error=%b overlap=%0d exp 0 0", error, overlap);
    end
  endtask

  task automatic test_hold_after_done;
    repeat (100) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || q_data.size() !== 4 || outData !== 16'h1900 || outAddr !== 16'd3) begin
      miscompares++;
      $display("FAIL hold_done got done=%b strobes=%0d data=%h addr=%h exp 1 4 1900 0003",
               done, q_data.size(), outData, outAddr);
    end
    stop_run();
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL release_done got done=%b error=%b exp 0 0", done, error);
    end
  endtask

  task automatic test_identity;
    int lat;
    logic [15:0] exp_id [4];
    exp_id = '{16'h0E00, 16'h0F00, 16'h1400, 16'h1500};
    for (int k = 0; k < 1024; k++) map_t[k] = 16'(k << 8);
    for (int k = 0; k < 25; k++) kernel_t[k] = 16'h0000;
    kernel_t[12] = 16'h0100;
    start_run(16'd6);
    wait_done(400, lat);
    vectors++;
    if (q_data.size() !== 4 || lat !== 105) begin
      miscompares++;
      $display("FAIL ident_count got %0d strobes lat %0d exp 4 105", q_data.size(), lat);
    end
    for (int n = 0; n < 4 && n < q_data.size(); n++) begin
      vectors++;
      if (q_data[n] !== exp_id[n] || q_addr[n] !== 16'(n)) begin
        miscompares++;
        $display("FAIL ident_pixel%0d got %h@%0d exp %h@%0d", n, q_data[n], q_addr[n], exp_id[n], n);
      end
    end
    stop_run();
  endtask

  task automatic test_sign_saturation;
    int lat;
    logic [15:0] mv  [3];
    logic [15:0] kv  [3];
    logic [15:0] exv [3];
    mv  = '{16'h0100, 16'h7FFF, 16'h7FFF};
    kv  = '{16'hFF00, 16'h7FFF, 16'h8001};
    exv = '{16'hE700, 16'h7FFF, 16'h8000};
    for (int s = 0; s < 3; s++) begin
      fill(mv[s], kv[s]);
      start_run(16'd6);
      wait_done(400, lat);
      vectors++;
      if (q_data.size() !== 4 || lat !== 105) begin
        miscompares++;
        $display("FAIL sign%0d_count got %0d strobes lat %0d exp 4 105", s, q_data.size(), lat);
      end
      for (int n = 0; n < q_data.size(); n++) begin
        vectors++;
        if (q_data[n] !== exv[s]) begin
          miscompares++;
          $display("FAIL sign%0d_pixel%0d got %h exp %h", s, n, q_data[n], exv[s]);
        end
      end
      stop_run();
    end
  endtask

  task automatic test_size_error;
    logic [15:0] bad [2];
    bad = '{16'd4, 16'd33};
    fill(16'h0100, 16'h0100);
    for (int s = 0; s < 2; s++) begin
      start_run(bad[s]);
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL err%0d_early_done got %b exp 0", bad[s], done);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || error !== 1'b1) begin
        miscompares++;
        $display("FAIL err%0d_flags got done=%b error=%b exp 1 1", bad[s], done, error);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (q_data.size() !== 0) begin
        miscompares++;
        $display("FAIL err%0d_strobes got %0d exp 0", bad[s], q_data.size());
      end
      stop_run();
      @(negedge clk);
      vectors++;
      if (error !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL err%0d_clear got done=%b error=%b exp 0 0", bad[s], done, error);
      end
    end
  endtask

  task automatic test_max_size;
    int lat;
    int bad_px;
    fill(16'h0100, 16'h0100);
    start_run(16'd32);
    wait_done(21000, lat);
    vectors++;
    if (lat !== 20385) begin
      miscompares++;
      $display("FAIL max_done_latency got %0d exp 20385", lat);
    end
    vectors++;
    if (q_data.size() !== 784) begin
      miscompares++;
      $display("FAIL max_strobes got %0d exp 784", q_data.size());
    end
    bad_px = 0;
    for (int n = 0; n < q_data.size(); n++)
      if (q_data[n] !== 16'h1900 || q_addr[n] !== 16'(n)) bad_px++;
    vectors++;
    if (bad_px !== 0) begin
      miscompares++;
      $display("FAIL max_pixels got %0d bad pixels exp 0", bad_px);
    end
    vectors++;
    if (outAddr !== 16'd783) begin
      miscompares++;
      $display("FAIL max_last_addr got %0d exp 783", outAddr);
    end
    stop_run();
  endtask

  task automatic test_abort;
    fill(16'h0100, 16'h0100);
    start_run(16'd6);
    repeat (39) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    repeat (80) @(negedge clk);
    vectors++;
    if (q_data.size() !== 1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort got strobes=%0d done=%b exp 1 0", q_data.size(), done);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    fill(16'h0100, 16'h0100);
    start_run(16'd6);
    repeat (30) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({outData, outAddr, outValid, done, error} !== 35'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h/%h/%b%b%b exp 0/0/000", outData, outAddr, outValid, done, error);
    end
    @(negedge clk);
    q_data.delete(); q_addr.delete(); q_time.delete();
    reset = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    wait_done(400, lat);
    vectors++;
    if (lat !== 105 || q_data.size() !== 4) begin
      miscompares++;
      $display("FAIL rerun got lat=%0d strobes=%0d exp 105 4", lat, q_data.size());
    end
    for (int n = 0; n < q_data.size(); n++) begin
      vectors++;
      if (q_data[n] !== 16'h1900 || q_addr[n] !== 16'(n)) begin
        miscompares++;
        $display("FAIL rerun_pixel%0d got %h@%0d exp 1900@%0d", n, q_data[n], q_addr[n], n);
      end
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_unit_conv();
    test_hold_after_done();
    test_identity();
    test_sign_saturation();
    test_size_error();
    test_abort();
    test_async_reset();
    test_max_size();
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL valid_with_done got %0d overlaps exp 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_window_engine.md
# conv_window_engine

Downstream consumer of the block loader in the CNN datapath. It takes the square feature-map block the loader has assembled (up to 32×32 words, row-major) plus a 5×5 kernel, and computes a valid-mode 2-D convolution. One multiply-accumulate is done per cycle, and each finished output pixel is streamed out with its linear output address. Output goes to the next stage (pooling/writeback) through a valid-strobe interface.

## Interface
- DATA_W, 16: word width; signed Q8.8 fixed point for map, kernel and output.
- K, 5: kernel edge; fixed 5 in this block.
- MAP_MAX, 32: maximum map edge; the map array depth is MAP_MAX*MAP_MAX = 1024.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces every register and output to its reset value immediately.
- enable  in  1  level start/hold; tied to the loader's done.
- size  in  16  map edge N; sampled at start.
- map  in  16 × [0:1023]  loaded block, row-major, row stride N; must stay stable while running.
- kernel  in  16 × [0:24]  kernel, row-major; must stay stable while running.
- outData  out  16  convolved pixel, Q8.8, saturated.
- outAddr  out  16  linear output index r*O + c, where O = N-4.
- outValid  out  1  one-cycle strobe qualifying outData/outAddr.
- done  out  1  run finished; held high while enable stays high.
- error  out  1  run rejected because N < 5 or N > 32; qualified by done.

## Operation
- States: IDLE, MAC, WRITE, DONE.
- IDLE, enable=1:
  - Capture N and clear the counters (r, c, i, j) and the accumulator.
  - If N is outside 5..32: go to DONE with error=1.
  - Otherwise: go to MAC with error=0.
- MAC, one product per cycle:
  - Product: acc += map[(r+i)*N + (c+j)] * kernel[i*5 + j], a signed 16×16→32 multiply.
  - Accumulator: 40-bit signed; it cannot overflow across 25 terms.
  - Sequencing: j counts 0..4 and then increments i. After (i,j)=(4,4), go to WRITE.
  - Map address: generated incrementally by adding rowBase and N. No multiplier on the address path.
- WRITE, one cycle:
  - outValid=1, outAddr=r*O+c.
  - outData = acc >>> 8 (arithmetic shift), saturated to 0x7FFF / 0x8000.
  - Clear acc. Advance c; when c wraps past O-1, advance r.
  - Next state: MAC, or DONE after pixel (O-1, O-1).
- DONE: done=1. When enable=0, return to IDLE, clearing done and error.
- enable=0 during MAC or WRITE aborts the run. Next state is IDLE; that cycle emits no outValid and the run never reaches done.
- Reset values: outData=0, outAddr=0, outValid=0, done=0, error=0, state=IDLE.

## Timing
- Let edge E0 be the rising edge at which IDLE samples enable=1.
- Pixel n (0-based) has outValid high during the cycle after edge E0 + 26(n+1).
- done rises at edge E0 + 26·O² + 1. Total latency is 26·O² + 1 cycles.
- Error path: done and error are high after edge E0 + 1, with zero outValid strobes.
- outValid is never high in the same cycle as done.
- outData/outAddr hold their last value between strobes.
- Throughput: one pixel per 26 cycles; no back-pressure.
- enable held high after done: stays in DONE; no re-run until enable falls and rises again.
- Async reset mid-run: outputs clear within the same cycle. After reset is released, the block is in IDLE and restarts only if enable=1 is sampled.

## Test plan
- **Unit conv:** N=6, map all 0x0100, kernel all 0x0100 → 4 strobes, addr 0,1,2,3, each data 0x1900. done at E0+105.
- **Identity/addressing:** N=6, map[k]=k·0x0100, kernel center (index 12)=0x0100, rest 0 → data 0x0E00, 0x0F00, 0x1400, 0x1500 at addr 0..3.
- **Sign/saturation:**
  - map all 0x0100, kernel all 0xFF00 → all outputs 0xE700.
  - map all 0x7FFF, kernel all 0x7FFF → 0x7FFF.
  - kernel all 0x8001 with map 0x7FFF → 0x8000.
- **Size errors:** N=4 → done=1 and error=1 after E0+1, no outValid. N=33 → same. N=32 → O=28, 784 strobes, last addr 783.
- **Abort/handshake:**
  - Drop enable at E0+40 → state IDLE, exactly 1 strobe seen, done never asserted.
  - Hold enable after done → done stays high, no extra strobes.
- **Reset:** assert reset low mid-MAC between edges → all outputs 0 immediately. Release with enable=1 → fresh run from pixel 0, correct data.
